// File: rtl/clock_set_ctrl_pkg.sv
// Shared field encodings and state type for the clock/calendar setting controller.
// The field code doubles as the FSM state so field_sel comes straight from the state register.
package clock_set_pkg;

   localparam logic [2:0] FIELD_RUN   = 3'd0;
   localparam logic [2:0] FIELD_HOUR  = 3'd1;
   localparam logic [2:0] FIELD_MIN   = 3'd2;
   localparam logic [2:0] FIELD_DAY   = 3'd3;
   localparam logic [2:0] FIELD_MONTH = 3'd4;
   localparam logic [2:0] FIELD_YEAR  = 3'd5;
   localparam int         FIELD_LAST  = 5;

   typedef enum logic [2:0] {
      ST_RUN   = FIELD_RUN,
      ST_HOUR  = FIELD_HOUR,
      ST_MIN   = FIELD_MIN,
      ST_DAY   = FIELD_DAY,
      ST_MONTH = FIELD_MONTH,
      ST_YEAR  = FIELD_YEAR
   } state_e;

   function automatic state_e next_field(input state_e s);
      if (s == state_e'(FIELD_LAST)) begin
         return ST_RUN;
      end else begin
         return state_e'(s + 3'd1);
      end
   endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Front-panel buttons in, field select / edit strobes out.
interface clock_set_ctrl_if;

   logic       btn_mode;
   logic       btn_up;
   logic       btn_down;
   logic [2:0] field_sel;
   logic       run_en;
   logic       inc_pulse;
   logic       dec_pulse;
   logic       sec_clr;

   modport master (
      output btn_mode, btn_up, btn_down,
      input  field_sel, run_en, inc_pulse, dec_pulse, sec_clr
   );

   modport slave (
      input  btn_mode, btn_up, btn_down,
      output field_sel, run_en, inc_pulse, dec_pulse, sec_clr
   );

endinterface

// File: rtl/clock_set_ctrl_btn_debounce_edge.sv
// One button: 2-flop synchronizer, stable-count debouncer and a registered one-cycle press.
module btn_debounce_edge #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_i,
   output logic level_o,
   output logic press_o
);

   localparam int            CW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    sync_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          db_q, db_d;
   logic          db_dly_q;
   logic          press_q;

   // the level only flips after the synchronized input disagrees for DEBOUNCE_CYCLES samples
   always_comb begin
      cnt_d = cnt_q;
      db_d  = db_q;
      if (sync_q[1] == db_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         db_d  = sync_q[1];
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q   <= 2'b00;
         cnt_q    <= '0;
         db_q     <= 1'b0;
         db_dly_q <= 1'b0;
         press_q  <= 1'b0;
      end else begin
         sync_q   <= {sync_q[0], btn_i};
         cnt_q    <= cnt_d;
         db_q     <= db_d;
         db_dly_q <= db_q;
         press_q  <= db_q & ~db_dly_q;
      end
   end

   assign level_o = db_q;
   assign press_o = press_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Edit-mode sequencer: debounced MODE/UP/DOWN drive field selection, inc/dec strobes and timeout.
// Optional auto-repeat on held UP/DOWN is built when CLOCK_SET_AUTO_REPEAT_EN is defined.
module clock_set_ctrl
   import clock_set_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int HOLD_CYCLES     = 50_000_000,
   parameter int REPEAT_CYCLES   = 10_000_000,
   parameter int TIMEOUT_CYCLES  = 500_000_000
) (
   input logic             clk,
   input logic             rst_n,
   clock_set_ctrl_if.slave bus
);

   localparam int            TW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);

   logic mode_lvl_s, mode_p_s, up_lvl_s, up_p_s, dn_lvl_s, dn_p_s;
   logic mode_ev_s, rep_fire_s;

   btn_debounce_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
      .clk(clk), .rst_n(rst_n), .btn_i(bus.btn_mode), .level_o(mode_lvl_s), .press_o(mode_p_s));
   btn_debounce_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
      .clk(clk), .rst_n(rst_n), .btn_i(bus.btn_up), .level_o(up_lvl_s), .press_o(up_p_s));
   btn_debounce_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
      .clk(clk), .rst_n(rst_n), .btn_i(bus.btn_down), .level_o(dn_lvl_s), .press_o(dn_p_s));

   // a press strobe is always accompanied by a high level; qualifying keeps the level in use
   assign mode_ev_s = mode_p_s & mode_lvl_s;

   state_e        state_q, state_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          run_en_q, run_en_d;
   logic          inc_q, inc_d, dec_q, dec_d, sec_q, sec_d;

`ifdef CLOCK_SET_AUTO_REPEAT_EN
   localparam int            RMAX     = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int            RW       = (RMAX > 1) ? $clog2(RMAX) : 1;
   localparam logic [RW-1:0] HOLD_LIM = RW'(HOLD_CYCLES - 1);
   localparam logic [RW-1:0] REP_LIM  = RW'(REPEAT_CYCLES - 1);

   logic [RW-1:0] rep_q, rep_d;
   logic          rep_first_q, rep_first_d;

   // hold timer restarts on any press, on MODE, in RUN, and unless exactly one of UP/DOWN is held
   always_comb begin
      rep_d       = rep_q;
      rep_first_d = rep_first_q;
      rep_fire_s  = 1'b0;
      if ((state_q == ST_RUN) || mode_ev_s || up_p_s || dn_p_s || (up_lvl_s == dn_lvl_s)) begin
         rep_d       = '0;
         rep_first_d = 1'b1;
      end else if (rep_q == (rep_first_q ? HOLD_LIM : REP_LIM)) begin
         rep_fire_s  = 1'b1;
         rep_d       = '0;
         rep_first_d = 1'b0;
      end else begin
         rep_d = rep_q + RW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rep_q       <= '0;
         rep_first_q <= 1'b1;
      end else begin
         rep_q       <= rep_d;
         rep_first_q <= rep_first_d;
      end
   end
`else
   assign rep_fire_s = 1'b0;
`endif

   // priority in an edit state: MODE, then UP/DOWN press, then repeat, then idle timeout
   always_comb begin
      state_d = state_q;
      tmo_d   = tmo_q;
      inc_d   = 1'b0;
      dec_d   = 1'b0;
      sec_d   = 1'b0;
      case (state_q)
         ST_RUN: begin
            tmo_d = '0;
            if (mode_ev_s) begin
               state_d = ST_HOUR;
               sec_d   = 1'b1;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_HOUR, ST_MIN, ST_DAY, ST_MONTH, ST_YEAR: begin
            if (mode_ev_s) begin
               state_d = next_field(state_q);
               tmo_d   = '0;
            end else if (up_p_s || dn_p_s) begin
               tmo_d = '0;
               inc_d = up_p_s & ~dn_p_s;
               dec_d = dn_p_s & ~up_p_s;
            end else if (rep_fire_s) begin
               tmo_d = '0;
               inc_d = up_lvl_s;
               dec_d = dn_lvl_s;
            end else if (tmo_q == TMO_MAX) begin
               state_d = ST_RUN;
               tmo_d   = '0;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         default: begin
            state_d = ST_RUN;
            tmo_d   = '0;
         end
      endcase
      run_en_d = (state_d == ST_RUN);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_RUN;
         tmo_q    <= '0;
         run_en_q <= 1'b1;
         inc_q    <= 1'b0;
         dec_q    <= 1'b0;
         sec_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         tmo_q    <= tmo_d;
         run_en_q <= run_en_d;
         inc_q    <= inc_d;
         dec_q    <= dec_d;
         sec_q    <= sec_d;
      end
   end

   assign bus.field_sel = state_q;
   assign bus.run_en    = run_en_q;
   assign bus.inc_pulse = inc_q;
   assign bus.dec_pulse = dec_q;
   assign bus.sec_clr   = sec_q;

endmodule
